ahb_gpio_slave: RTL and testbench
=================================

// Module: ahb_gpio_slave
// PURPOSE
// - AHB-Lite responder (slave) that memory-maps the board LEDs, slide switches and a cycle counter.
// - Sits on the core's ldst data-bus initiator, alongside dcache, behind the bus select.
// - Replaces driving LEDs straight from the instruction address; firmware reads/writes registers instead.
// - Supports programmable wait states and the AHB two-cycle ERROR response.
// PARAMETERS
// ADDR_WIDTH   32        haddr width; only haddr[3:0] decoded, upper bits ignored (aliased)
// DATA_WIDTH   32        hwdata/hrdata width; fixed at 32
// WAIT_STATES  0         hready-low cycles inserted in every OKAY data phase (0..15)
// LED_RESET    16'h0000  LED register value after reset
// PORTS
// HCLK       in   1           bus clock; all logic on rising edge
// HRESETn    in   1           asynchronous active-low reset
// hsel       in   1           slave select from bus decode
// haddr      in   ADDR_WIDTH  address-phase address
// htrans     in   2           transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
// hwrite     in   1           1=write, 0=read
// hsize      in   3           0=byte, 1=half, 2=word; others illegal
// hburst     in   3           ignored; each beat handled independently
// hprot      in   4           ignored
// hmastlock  in   1           ignored
// hwdata     in   DATA_WIDTH  write data, data phase
// hrdata     out  DATA_WIDTH  read data, data phase
// hready     out  1           transfer done / bus ready; single-slave bus, also used as bus HREADY
// hresp      out  1           0=OKAY, 1=ERROR
// sw_in      in   16          asynchronous switch inputs
// led        out  16          LED register contents
// BEHAVIOUR
// - Reset: hready=1, hresp=0, hrdata=0, led=LED_RESET, cycle counter=0, sync flops=0, state=IDLE.
// - Register map, offset haddr[3:0]:
//   0x0 LED: RW; bits[15:0]; bytes 2-3 write-ignored, read 0.
//   0x4 LED_TGL: WO; led <= led ^ hwdata[15:0] (byte-lane masked); reads 0.
//   0x8 SW: RO; sw_in via 2-flop synchroniser; bits[31:16] read 0.
//   0xC CYCLES: RO; 32-bit free-running, +1 every cycle, wraps 0xFFFFFFFF->0.
// - Accept: sampled when hsel & htrans[1] & hready; capture addr[3:0], hwrite and hsize. IDLE/BUSY or hsel=0 -> zero-wait OKAY.
// - Error on accept: hsize>2; word with haddr[1:0]!=0; half with haddr[0]=1; write to 0x8 or 0xC.
// - FSM:
//   IDLE -> WAIT when accepted OKAY and WAIT_STATES>0.
//   IDLE -> DATA when accepted OKAY and WAIT_STATES=0.
//   IDLE -> ERR1 when accepted error.
//   WAIT: hready=0; counts WAIT_STATES cycles, then -> DATA.
//   DATA: hready=1, hresp=0; final cycle.
//   ERR1: hready=0, hresp=1.
//   ERR2: hready=1, hresp=1.
//   DATA/ERR2 -> next state per a new accept in the same cycle (pipelined), else IDLE.
// - Errors never insert wait states: ERROR response always exactly 2 cycles.
// - Write commit: hwdata sampled at DATA-cycle edge; byte lanes from hsize/addr[1:0].
// - Read: hrdata = selected register during DATA of a read; 0 in every other cycle.
//   CYCLES value is taken in that DATA cycle.
// - Address inputs ignored while hready=0; ERROR transfers change no register.
// - Back-to-back: accept in DATA cycle of previous beat -> next beat follows with no idle cycle.
// - Reset mid-transfer: immediate IDLE, outputs to reset values; transfer in flight discarded.
// TESTING
// - WAIT_STATES=0: NONSEQ word write 0x0=0x1234ABCD, read 0x0 -> led=0xABCD, hrdata=0x0000ABCD, hready never low.
// - WAIT_STATES=3: read 0x8 with sw_in=0x00A5 steady -> hready low 3 cycles, then hrdata=0x000000A5, hresp=0.
// - Byte write 0x55 to addr 0x1 with led=0xABCD -> led=0x55CD; write 0x00FF to 0x4 -> led=0x5532.
// - Word write to 0xC, then half read at 0x3 -> each 2-cycle ERROR (hready 0 then 1, hresp=1); CYCLES unchanged by write.
// - Back-to-back NONSEQ writes 0x0=1, 0x0=2, then IDLE -> each beat completes in one cycle; led=0x0002; then hready=1, hresp=0.
// - Assert HRESETn low during WAIT of a read -> hready=1, hrdata=0, led=LED_RESET on the next edge; the next accepted transfer is OKAY.

Source files
------------

// File: rtl/ahb_gpio_slave.sv
// ahb_gpio_slave: AHB-Lite responder exposing board LEDs, slide switches and
// a free-running cycle counter. Supports programmable OKAY wait states and the
// two-cycle ERROR response. hready/hresp/hrdata are driven from registers that
// are loaded with the values belonging to the state being entered.
module ahb_gpio_slave #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          WAIT_STATES = 0,
  parameter logic [15:0] LED_RESET   = 16'h0000
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic                  hmastlock,
  input  logic [DATA_WIDTH-1:0] hwdata,
  output logic [DATA_WIDTH-1:0] hrdata,
  output logic                  hready,
  output logic                  hresp,
  input  logic [15:0]           sw_in,
  output logic [15:0]           led
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  localparam logic       HAS_WAIT_C = (WAIT_STATES > 0);
  localparam logic [3:0] WS_LAST_C  = 4'(WAIT_STATES - 1);

  // Byte lanes touched by a transfer of the given size at the given offset.
  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Transfer-level error: illegal size, misalignment, or write to a read-only register.
  function automatic logic req_error(input logic [2:0] sz, input logic [3:0] a, input logic wr);
    return (sz > 3'd2) |
           ((sz == 3'd2) & (a[1:0] != 2'b00)) |
           ((sz == 3'd1) & a[0]) |
           (wr & a[3]);
  endfunction

  state_t      state_r, state_nxt_s;
  logic [3:0]  addr_r;
  logic        write_r;
  logic [2:0]  size_r;
  logic [3:0]  wait_cnt_r;
  logic [15:0] led_r, led_nxt_s;
  logic [31:0] cycles_r;
  logic [15:0] sw_meta_r, sw_sync_r;
  logic        hready_r, hresp_r;
  logic [31:0] hrdata_r;
  logic        hready_nxt_s, hresp_nxt_s;
  logic [31:0] hrdata_nxt_s, rd_value_s;
  logic        accept_s, req_err_s;
  logic [3:0]  beat_addr_s, wr_lanes_s;
  logic        beat_write_s;
  logic        unused_s;

  assign accept_s     = hsel & htrans[1] & hready_r;
  assign req_err_s    = req_error(hsize, haddr[3:0], hwrite);
  // The beat whose data phase is being entered: a fresh accept, or the one held through WAIT.
  assign beat_addr_s  = (state_r == ST_WAIT) ? addr_r  : haddr[3:0];
  assign beat_write_s = (state_r == ST_WAIT) ? write_r : hwrite;
  assign wr_lanes_s   = lane_mask(size_r, addr_r[1:0]);

  assign hrdata = hrdata_r;
  assign hready = hready_r;
  assign hresp  = hresp_r;
  assign led    = led_r;

  assign unused_s = ^{haddr[ADDR_WIDTH-1:4], htrans[0], hburst, hprot, hmastlock,
                      hwdata[DATA_WIDTH-1:16], wr_lanes_s[3:2]};

  // State register and registered bus outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r  <= ST_IDLE;
      hready_r <= 1'b1;
      hresp_r  <= 1'b0;
      hrdata_r <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      hready_r <= hready_nxt_s;
      hresp_r  <= hresp_nxt_s;
      hrdata_r <= hrdata_nxt_s;
    end
  end

  // Next-state decode; DATA and ERR2 may accept a pipelined beat directly.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (req_err_s) begin
            state_nxt_s = ST_ERR1;
          end else if (HAS_WAIT_C) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_r == WS_LAST_C) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_ERR1: state_nxt_s = ST_ERR2;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Read mux using the register values that will be visible during the DATA cycle.
  always_comb begin
    rd_value_s = 32'h0000_0000;
    case (beat_addr_s[3:2])
      2'd0:    rd_value_s = {16'h0000, led_nxt_s};
      2'd1:    rd_value_s = 32'h0000_0000;
      2'd2:    rd_value_s = {16'h0000, sw_meta_r};
      2'd3:    rd_value_s = cycles_r + 32'd1;
      default: rd_value_s = 32'h0000_0000;
    endcase
  end

  // Output decode from the state being entered.
  always_comb begin
    hready_nxt_s = 1'b1;
    hresp_nxt_s  = 1'b0;
    hrdata_nxt_s = 32'h0000_0000;
    case (state_nxt_s)
      ST_WAIT: hready_nxt_s = 1'b0;
      ST_ERR1: begin
        hready_nxt_s = 1'b0;
        hresp_nxt_s  = 1'b1;
      end
      ST_ERR2: hresp_nxt_s = 1'b1;
      ST_DATA: begin
        if (!beat_write_s) begin
          hrdata_nxt_s = rd_value_s;
        end else begin
          hrdata_nxt_s = 32'h0000_0000;
        end
      end
      default: hready_nxt_s = 1'b1;
    endcase
  end

  // LED update: write commits at the end of the DATA cycle, lanes from captured size/offset.
  always_comb begin
    led_nxt_s = led_r;
    if ((state_r == ST_DATA) && write_r) begin
      case (addr_r[3:2])
        2'd0: led_nxt_s = {wr_lanes_s[1] ? hwdata[15:8] : led_r[15:8],
                           wr_lanes_s[0] ? hwdata[7:0]  : led_r[7:0]};
        2'd1: led_nxt_s = led_r ^ ({wr_lanes_s[1] ? 8'hFF : 8'h00,
                                    wr_lanes_s[0] ? 8'hFF : 8'h00} & hwdata[15:0]);
        default: led_nxt_s = led_r;
      endcase
    end else begin
      led_nxt_s = led_r;
    end
  end

  // Beat capture, wait counter, LED/counter state and switch synchroniser.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_r     <= 4'h0;
      write_r    <= 1'b0;
      size_r     <= 3'd0;
      wait_cnt_r <= 4'd0;
      led_r      <= LED_RESET;
      cycles_r   <= 32'h0000_0000;
      sw_meta_r  <= 16'h0000;
      sw_sync_r  <= 16'h0000;
    end else begin
      if (accept_s) begin
        addr_r  <= haddr[3:0];
        write_r <= hwrite;
        size_r  <= hsize;
      end
      if ((state_nxt_s == ST_WAIT) && (state_r == ST_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + 4'd1;
      end else begin
        wait_cnt_r <= 4'd0;
      end
      led_r     <= led_nxt_s;
      cycles_r  <= cycles_r + 32'd1;
      sw_meta_r <= sw_in;
      sw_sync_r <= sw_meta_r;
    end
  end

endmodule

// File: tb/tb_ahb_gpio_slave.sv
// Directed bench for ahb_gpio_slave: one instance with no wait states and one
// with three wait states, driven one at a time through a shared bus.
module tb_ahb_gpio_slave;

  logic        clk;
  logic        rst_n;
  logic        hsel0, hsel3;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic [15:0] sw_in;
  logic [31:0] hrdata0, hrdata3;
  logic        hready0, hready3, hresp0, hresp3;
  logic [15:0] led0, led3;

  logic        tgt;
  logic [31:0] hrdata_t;
  logic        hready_t, hresp_t;

  int vecs;
  int miscompares;

  assign hrdata_t = tgt ? hrdata3 : hrdata0;
  assign hready_t = tgt ? hready3 : hready0;
  assign hresp_t  = tgt ? hresp3  : hresp0;

  ahb_gpio_slave #(.WAIT_STATES(0)) u_dut0 (
    .HCLK(clk), .HRESETn(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
    .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0), .hresp(hresp0),
    .sw_in(sw_in), .led(led0)
  );

  ahb_gpio_slave #(.WAIT_STATES(3), .LED_RESET(16'hC3C3)) u_dut3 (
    .HCLK(clk), .HRESETn(rst_n), .hsel(hsel3), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(3'd0), .hprot(4'd0), .hmastlock(1'b0),
    .hwdata(hwdata), .hrdata(hrdata3), .hready(hready3), .hresp(hresp3),
    .sw_in(sw_in), .led(led3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Single non-pipelined beat; starts and ends 1 time unit after a rising edge.
  task automatic xfer(input logic wr, input logic [2:0] sz, input logic [3:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic rs, output int waits);
    int guard;
    if (tgt) hsel3 = 1'b1; else hsel0 = 1'b1;
    htrans = 2'b10;
    haddr  = {28'h0, a};
    hwrite = wr;
    hsize  = sz;
    @(posedge clk); #1;
    hsel0  = 1'b0;
    hsel3  = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    waits  = 0;
    guard  = 0;
    while ((hready_t !== 1'b1) && (guard < 40)) begin
      waits++;
      guard++;
      @(posedge clk); #1;
    end
    if (guard >= 40) begin
      vecs++;
      miscompares++;
      $error("FAIL xfer_timeout: observed hready low for %0d cycles expected completion", guard);
    end
    rd = hrdata_t;
    rs = hresp_t;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, c1, c2;
    logic        rs;
    int          w;
    vecs = 0; miscompares = 0;
    tgt = 1'b0;
    rst_n = 1'b0;
    hsel0 = 1'b0; hsel3 = 1'b0; haddr = 32'h0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = 32'h0;
    sw_in = 16'h00A5;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset values
    check("rst_hready0", {31'h0, hready0}, 32'h1);
    check("rst_hresp0",  {31'h0, hresp0},  32'h0);
    check("rst_hrdata0", hrdata0, 32'h0);
    check("rst_led0",    {16'h0, led0}, 32'h0000);
    check("rst_led3",    {16'h0, led3}, 32'h0000_C3C3);

    // Zero-wait word write and read of LED
    xfer(1'b1, 3'd2, 4'h0, 32'h1234_ABCD, rd, rs, w);
    check("w0_waits", w, 0);
    check("w0_resp",  {31'h0, rs}, 32'h0);
    check("w0_led",   {16'h0, led0}, 32'h0000_ABCD);
    xfer(1'b0, 3'd2, 4'h0, 32'h0, rd, rs, w);
    check("r0_waits", w, 0);
    check("r0_data",  rd, 32'h0000_ABCD);
    check("r0_idle_hrdata", hrdata0, 32'h0);

    // Byte-lane write, toggle register, ignored upper half
    xfer(1'b1, 3'd0, 4'h1, 32'h0000_5500, rd, rs, w);
    check("byte_led", {16'h0, led0}, 32'h0000_55CD);
    xfer(1'b1, 3'd2, 4'h4, 32'h0000_00FF, rd, rs, w);
    check("tgl_led", {16'h0, led0}, 32'h0000_5532);
    xfer(1'b1, 3'd1, 4'h2, 32'hFFFF_FFFF, rd, rs, w);
    check("hi_half_led", {16'h0, led0}, 32'h0000_5532);
    xfer(1'b0, 3'd2, 4'h4, 32'h0, rd, rs, w);
    check("tgl_read", rd, 32'h0);
    xfer(1'b0, 3'd2, 4'h8, 32'h0, rd, rs, w);
    check("sw_read0", rd, 32'h0000_00A5);

    // Error responses; CYCLES keeps counting, registers untouched
    xfer(1'b0, 3'd2, 4'hC, 32'h0, c1, rs, w);
    xfer(1'b1, 3'd2, 4'hC, 32'h0000_0000, rd, rs, w);
    check("err_wc_waits", w, 1);
    check("err_wc_resp",  {31'h0, rs}, 32'h1);
    xfer(1'b0, 3'd2, 4'hC, 32'h0, c2, rs, w);
    check("cycles_delta", c2 - c1, 32'd5);
    xfer(1'b0, 3'd1, 4'h3, 32'h0, rd, rs, w);
    check("err_half_waits", w, 1);
    check("err_half_resp",  {31'h0, rs}, 32'h1);
    xfer(1'b1, 3'd2, 4'h2, 32'hFFFF_FFFF, rd, rs, w);
    check("err_misal_resp", {31'h0, rs}, 32'h1);
    check("err_misal_led",  {16'h0, led0}, 32'h0000_5532);
    xfer(1'b0, 3'd3, 4'h0, 32'h0, rd, rs, w);
    check("err_size_resp", {31'h0, rs}, 32'h1);

    // Back-to-back pipelined writes
    hsel0 = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    check("b2b_rdy1", {31'h0, hready0}, 32'h1);
    hwdata = 32'h0000_0001;
    htrans = 2'b10; haddr = 32'h0;
    @(posedge clk); #1;
    check("b2b_rdy2", {31'h0, hready0}, 32'h1);
    check("b2b_led1", {16'h0, led0}, 32'h0000_0001);
    hwdata = 32'h0000_0002;
    hsel0 = 1'b0; htrans = 2'b00;
    @(posedge clk); #1;
    check("b2b_led2",  {16'h0, led0}, 32'h0000_0002);
    check("b2b_ready", {31'h0, hready0}, 32'h1);
    check("b2b_resp",  {31'h0, hresp0}, 32'h0);

    // Wait-state instance
    tgt = 1'b1;
    xfer(1'b0, 3'd2, 4'h8, 32'h0, rd, rs, w);
    check("ws_sw_waits", w, 3);
    check("ws_sw_data",  rd, 32'h0000_00A5);
    check("ws_sw_resp",  {31'h0, rs}, 32'h0);
    xfer(1'b1, 3'd2, 4'h0, 32'h0000_1111, rd, rs, w);
    check("ws_w_waits", w, 3);
    check("ws_w_led",   {16'h0, led3}, 32'h0000_1111);
    xfer(1'b1, 3'd2, 4'hC, 32'h0, rd, rs, w);
    check("ws_err_waits", w, 1);
    check("ws_err_resp",  {31'h0, rs}, 32'h1);

    // Reset during WAIT of a read
    hsel3 = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    hsel3 = 1'b0; htrans = 2'b00;
    check("mid_wait_low", {31'h0, hready3}, 32'h0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {31'h0, hready3}, 32'h1);
    check("mid_rst_hrdata", hrdata3, 32'h0);
    check("mid_rst_led3", {16'h0, led3}, 32'h0000_C3C3);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 3'd2, 4'h0, 32'h0, rd, rs, w);
    check("post_rst_waits", w, 3);
    check("post_rst_resp",  {31'h0, rs}, 32'h0);
    check("post_rst_data",  rd, 32'h0000_C3C3);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
